// File: rtl/eth_helper_pkg.sv
// Shared types and word builders for the AXI R-channel stream tap.
package eth_helper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } out_state_e;

    localparam int DROP_MODE_STALL = 0;
    localparam int DROP_MODE_DROP  = 1;

    // Builders work on a wide scratch word; callers size-cast to DATA_WIDTH.
    localparam int MAX_WORD_W = 1024;
    typedef logic [MAX_WORD_W-1:0] word_max_t;

    // Stream type tag placed in the top tw bits of a dw-bit word.
    function automatic word_max_t tag_word(input int dw, input int tw, input word_max_t stype);
        return (stype & ((word_max_t'(1) << tw) - word_max_t'(1))) << (dw - tw);
    endfunction

    function automatic word_max_t mk_header(input int dw, input int tw,
                                            input word_max_t stype, input word_max_t id);
        return tag_word(dw, tw, stype) | id;
    endfunction

    function automatic word_max_t mk_error(input int dw, input int tw,
                                           input word_max_t stype, input logic [1:0] resp);
        return tag_word(dw, tw, stype) | word_max_t'(resp);
    endfunction

    // Terminator: tag plus the flag bit just below it.
    function automatic word_max_t mk_terminator(input int dw, input int tw, input word_max_t stype);
        return tag_word(dw, tw, stype) | (word_max_t'(1) << (dw - tw - 1));
    endfunction

endpackage

// File: rtl/stream_tap_fifo.sv
// Synchronous beat FIFO; full/empty come from registered wrap-bit pointers.
module stream_tap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail slot.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axi_r_stream_tap.sv
// AXI R-channel tap: forwards R unchanged, buffers accepted beats and replays
// each burst to the stream arbiter as a header word followed by its data.
module axi_r_stream_tap
    import eth_helper_pkg::*;
#(
    parameter int                           DATA_WIDTH        = 128,
    parameter int                           ID_WIDTH          = 32,
    parameter int                           USER_WIDTH        = 64,
    parameter int                           STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b010,
    parameter int                           FIFO_DEPTH        = 4,
    parameter int                           DROP_MODE         = 0,
    parameter int                           DROP_CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ready,
    output logic                      valid,
    output logic                      in_progress,
    output logic                      last,
    output logic [DATA_WIDTH-1:0]     data,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    input  logic [ID_WIDTH-1:0]       AXIM_rid,
    input  logic [DATA_WIDTH-1:0]     AXIM_rdata,
    input  logic [1:0]                AXIM_rresp,
    input  logic                      AXIM_rlast,
    input  logic [USER_WIDTH-1:0]     AXIM_ruser,
    input  logic                      AXIM_rvalid,
    output logic                      AXIM_rready,
    output logic [ID_WIDTH-1:0]       AXIS_rid,
    output logic [DATA_WIDTH-1:0]     AXIS_rdata,
    output logic [1:0]                AXIS_rresp,
    output logic                      AXIS_rlast,
    output logic [USER_WIDTH-1:0]     AXIS_ruser,
    output logic                      AXIS_rvalid,
    input  logic                      AXIS_rready
);
    localparam int ENTRY_W = 1 + ID_WIDTH + DATA_WIDTH;

    logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0]        fifo_din, fifo_dout;
    logic                      head_last;
    logic [ID_WIDTH-1:0]       head_id;
    logic [DATA_WIDTH-1:0]     head_word;
    logic                      beat, push_beat, push_term, drop_beat;
    logic [DATA_WIDTH-1:0]     beat_word, term_word;
    logic                      mid_burst_q, mid_burst_d;
    logic                      discarding_q, discarding_d;
    logic                      trunc_pending_q, trunc_pending_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    out_state_e                state_q, state_d;

    assign AXIS_rid   = AXIM_rid;
    assign AXIS_rdata = AXIM_rdata;
    assign AXIS_rresp = AXIM_rresp;
    assign AXIS_rlast = AXIM_rlast;
    assign AXIS_ruser = AXIM_ruser;

    // Stall policy gates the handshake on FIFO space; reset reopens the channel.
    always_comb begin
        if (DROP_MODE == DROP_MODE_STALL) begin
            AXIS_rvalid = AXIM_rvalid && (!fifo_full || reset);
            AXIM_rready = AXIS_rready && (!fifo_full || reset);
        end else begin
            AXIS_rvalid = AXIM_rvalid;
            AXIM_rready = AXIS_rready;
        end
    end

    assign beat      = AXIM_rvalid && AXIM_rready;
    assign beat_word = AXIM_rresp[1]
                     ? DATA_WIDTH'(mk_error(DATA_WIDTH, STREAM_TYPE_WIDTH,
                                            word_max_t'(STREAM_TYPE), AXIM_rresp))
                     : AXIM_rdata;
    assign term_word = DATA_WIDTH'(mk_terminator(DATA_WIDTH, STREAM_TYPE_WIDTH,
                                                 word_max_t'(STREAM_TYPE)));

    // Decide whether this cycle pushes a beat, a terminator, or drops the beat.
    always_comb begin
        push_beat = 1'b0;
        push_term = 1'b0;
        drop_beat = 1'b0;
        if (DROP_MODE == DROP_MODE_STALL) begin
            push_beat = beat;
        end else begin
            push_term = trunc_pending_q && !fifo_full;
            push_beat = beat && !fifo_full && !discarding_q && !trunc_pending_q;
            drop_beat = beat && !push_beat;
        end
    end

    assign fifo_push = push_beat || push_term;
    assign fifo_din  = push_term ? {1'b1, {ID_WIDTH{1'b0}}, term_word}
                                 : {AXIM_rlast, AXIM_rid, beat_word};

    // Burst tracking and drop bookkeeping; only a fresh mid-burst drop truncates.
    always_comb begin
        mid_burst_d     = mid_burst_q;
        discarding_d    = discarding_q;
        trunc_pending_d = trunc_pending_q;
        drop_count_d    = drop_count_q;
        if (beat) begin
            mid_burst_d = !AXIM_rlast;
        end
        if (push_term) begin
            trunc_pending_d = 1'b0;
        end
        if (drop_beat) begin
            discarding_d = !AXIM_rlast;
            if (mid_burst_q && !discarding_q) begin
                trunc_pending_d = 1'b1;
            end
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end else if (beat && AXIM_rlast) begin
            discarding_d = 1'b0;
        end
    end

    // Control registers for burst tracking and drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_burst_q     <= 1'b0;
            discarding_q    <= 1'b0;
            trunc_pending_q <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            mid_burst_q     <= mid_burst_d;
            discarding_q    <= discarding_d;
            trunc_pending_q <= trunc_pending_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;

    stream_tap_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_last = fifo_dout[ENTRY_W-1];
    assign head_id   = fifo_dout[DATA_WIDTH +: ID_WIDTH];
    assign head_word = fifo_dout[DATA_WIDTH-1:0];

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a first beat being pushed opens the header without waiting a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty || push_beat) state_d = HEADER;
            HEADER:  if (ready) state_d = DATA;
            DATA:    if (fifo_pop && head_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stream outputs and FIFO pop; everything is held quiet while reset is high.
    always_comb begin
        valid       = 1'b0;
        last        = 1'b0;
        in_progress = 1'b0;
        data        = '0;
        fifo_pop    = 1'b0;
        if (!reset) begin
            case (state_q)
                HEADER: begin
                    valid       = 1'b1;
                    in_progress = 1'b1;
                    data        = DATA_WIDTH'(mk_header(DATA_WIDTH, STREAM_TYPE_WIDTH,
                                                        word_max_t'(STREAM_TYPE),
                                                        word_max_t'(head_id)));
                end
                DATA: begin
                    valid       = !fifo_empty;
                    in_progress = 1'b1;
                    data        = head_word;
                    last        = head_last;
                    fifo_pop    = !fifo_empty && ready;
                end
                default: ;
            endcase
        end
    end

endmodule
